text_ctrl: RTL and testbench
============================

# text_ctrl

Sequencing controller between the keyboard character buffer and the LCD refresh engine. It pops characters from the buffer over a ready/read handshake and interprets printable and control codes. It maintains a 32-cell (2×16) text store with a cursor and serves the LCD's continuous address/data read port. It owns all writes to the display text, including the line-2-to-line-1 scroll and full clear.

## Interface
Parameters: none (geometry fixed at 2 lines × 16 cells, 8-bit codes).
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- char_in  in  8  head character of buffer; valid while read_ready=1
- read_ready  in  1  buffer non-empty
- read  out  1  one-cycle pop strobe to buffer
- lcd_addr  in  5  LCD read address (0–15 line 1, 16–31 line 2)
- lcd_char  out  8  registered text store contents at lcd_addr
- cursor  out  5  next write cell
- busy  out  1  high while in CLEAR or SCROLL

## Operation
- Store: 32 × 8-bit register array. Blank = 0x20.
- States:
  - IDLE: if read_ready=1, assert read, latch char_in into cmd, go DECODE.
  - DECODE: classify cmd (rules below).
  - SCROLL: index i = 0..15; each cycle mem[i]←mem[i+16], mem[i+16]←0x20. After i=15: cursor←16, go IDLE.
  - CLEAR: index i = 0..15; each cycle mem[i]←0x20, mem[i+16]←0x20. After i=15: cursor←0, go IDLE.
- Decode rules:
  - 0x20–0x7E (printable): mem[cursor]←cmd.
    - cursor<31: cursor+1, go IDLE.
    - cursor=31: go SCROLL.
  - 0x08 (backspace):
    - cursor>0: cursor−1, mem[cursor−1]←0x20.
    - cursor=0: no-op.
    - Go IDLE in both cases.
  - 0x0D (enter):
    - cursor<16: cursor←16, go IDLE.
    - cursor≥16: go SCROLL.
  - 0x1B (escape): go CLEAR.
  - Any other code: discarded (already popped), go IDLE.
- Backspace does not cross into line 1 by scrolling back; it crosses by plain decrement (16→15 is allowed).
- LCD port:
  - Every cycle, lcd_char←mem[lcd_addr], giving read-before-write semantics.
  - Never stalled.
  - Served in all states, including reset clear.
- Reset: rst=1 at any edge forces CLEAR with i=0, read=0, cursor=0, lcd_char=0x20. This applies mid-SCROLL and mid-DECODE; any latched cmd is dropped.
- Reset values: read=0, busy=1 (CLEAR begins), cursor=0, lcd_char=0x20. Store contents are undefined until CLEAR completes, and lcd_char is forced to 0x20 while rst=1.

## Timing
- read:
  - Asserted combinationally with state=IDLE ∧ read_ready ∧ ¬rst.
  - Exactly 1 cycle per character.
  - Never asserted in DECODE, SCROLL or CLEAR.
- char_in is sampled in the same cycle read=1; the buffer advances its head on that edge.
- Printable/backspace/enter without scroll:
  - Pop at cycle t, store update and cursor visible at t+2.
  - Throughput is 1 char per 2 cycles with a continuously ready buffer.
- Scroll: pop t, DECODE t+1, SCROLL t+2..t+17, IDLE at t+18, cursor=16 from t+18.
- Clear via escape: same 16-cycle body. After rst deasserts, busy drops 16 cycles later.
- busy=1 exactly during SCROLL/CLEAR cycles. The printable write of cmd at cursor 31 lands in DECODE before the scroll, so the char appears at cell 15 after the scroll.
- lcd_char latency: 1 cycle from lcd_addr. A write at edge e is visible on lcd_char at edge e+1 if addressed.
- Cursor is always in range 0–31. No increment past 31 occurs (the scroll path handles it).

## Test plan
- Reset:
  - Stimulus: hold rst 1 cycle, release, wait 16 cycles, sweep lcd_addr 0–31.
  - Response: all lcd_char=0x20, cursor=0, busy high exactly 16 cycles then low, read=0 throughout.
- Type "AB":
  - Stimulus: buffer presents 0x41, then 0x42, read_ready held.
  - Response: read pulses 1 cycle each, 2 cycles apart; mem[0]=0x41, mem[1]=0x42; cursor=2.
- Fill and scroll:
  - Stimulus: 32 printable chars 0x41+n (wrapping within 0x41–0x5A).
  - Response: after char 32, busy 16 cycles; cells 0–15 hold old chars 16–31 (last = char 32 at cell 15); cells 16–31 = 0x20; cursor=16.
- Control codes:
  - Stimulus: at cursor=3, send 0x08, 0x0D, 0x07, 0x08.
  - Response: cell 2=0x20, cursor 2; then cursor 16; 0x07 popped and ignored; then cursor 15, cell 15=0x20.
- Backspace at 0 and escape:
  - Stimulus: 0x08 at cursor 0, then 0x1B with text present.
  - Response: no change; then all cells 0x20, cursor 0, busy 16 cycles.
- Reset mid-scroll:
  - Stimulus: assert rst at SCROLL i=5 while read_ready=1.
  - Response: no read pulse during rst or the following CLEAR; all cells 0x20 after 16 cycles; cursor=0; the next pop starts in the first IDLE cycle.

Source files
------------

// File: rtl/text_ctrl.sv
// text_ctrl: sits between the keyboard character buffer and the LCD refresh
// engine. It pops characters, interprets printable and control codes, keeps
// the 2x16 text store and cursor, and serves the LCD read port every cycle.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for the buffer; pops one character when it is ready
//   DECODE | classifies the latched code and applies write/cursor changes
//   SCROLL | 16-cycle body: line 2 moves to line 1, line 2 is blanked
//   CLEAR  | 16-cycle body: both lines blanked (also entered from reset)

module text_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       read_ready,
  output logic       read,
  input  logic [4:0] lcd_addr,
  output logic [7:0] lcd_char,
  output logic [4:0] cursor,
  output logic       busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_SCROLL = 2'd2;
  localparam logic [1:0] S_CLEAR  = 2'd3;

  localparam logic [7:0] BLANK    = 8'h20;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;
  localparam logic [7:0] CODE_BS  = 8'h08;
  localparam logic [7:0] CODE_CR  = 8'h0D;
  localparam logic [7:0] CODE_ESC = 8'h1B;

  localparam logic [4:0] FIRST_CELL  = 5'd0;
  localparam logic [4:0] LINE2_START = 5'd16;
  localparam logic [4:0] LAST_CELL   = 5'd31;
  localparam logic [3:0] LAST_IDX    = 4'd15;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] cmd;
  logic [3:0] idx;
  logic [4:0] cursor_nxt;
  logic [7:0] mem [0:31];

  // Write ports: port a covers any single cell (decode writes and the
  // line-1 half of the bodies); port b always targets the line-2 cell
  // paired with idx and always writes a blank.
  logic       we_a;
  logic [4:0] addr_a;
  logic [7:0] data_a;
  logic       we_b;
  logic [4:0] addr_b;

  logic is_print;
  logic is_bs;
  logic is_cr;
  logic is_esc;
  logic body_last;
  logic in_body;

  assign is_print  = (cmd >= PRINT_LO) && (cmd <= PRINT_HI);
  assign is_bs     = (cmd == CODE_BS);
  assign is_cr     = (cmd == CODE_CR);
  assign is_esc    = (cmd == CODE_ESC);
  assign body_last = (idx == LAST_IDX);
  assign in_body   = (state == S_SCROLL) || (state == S_CLEAR);
  assign addr_b    = {1'b1, idx};

  assign read = (state == S_IDLE) && read_ready && !rst;
  assign busy = in_body;

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_nxt  = state;
    cursor_nxt = cursor;
    we_a       = 1'b0;
    addr_a     = cursor;
    data_a     = cmd;
    we_b       = 1'b0;
    case (state)
      S_IDLE: begin
        if (read_ready) begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        state_nxt = S_IDLE;
        if (is_print) begin
          // The character lands at cell 31 before the scroll moves it to 15.
          we_a   = 1'b1;
          addr_a = cursor;
          data_a = cmd;
          if (cursor == LAST_CELL) begin
            state_nxt = S_SCROLL;
          end else begin
            cursor_nxt = cursor + 5'd1;
          end
        end else if (is_bs) begin
          if (cursor != FIRST_CELL) begin
            cursor_nxt = cursor - 5'd1;
            we_a       = 1'b1;
            addr_a     = cursor - 5'd1;
            data_a     = BLANK;
          end
        end else if (is_cr) begin
          if (cursor < LINE2_START) begin
            cursor_nxt = LINE2_START;
          end else begin
            state_nxt = S_SCROLL;
          end
        end else if (is_esc) begin
          state_nxt = S_CLEAR;
        end
      end
      S_SCROLL: begin
        we_a   = 1'b1;
        addr_a = {1'b0, idx};
        data_a = mem[addr_b];
        we_b   = 1'b1;
        if (body_last) begin
          state_nxt  = S_IDLE;
          cursor_nxt = LINE2_START;
        end
      end
      S_CLEAR: begin
        we_a   = 1'b1;
        addr_a = {1'b0, idx};
        data_a = BLANK;
        we_b   = 1'b1;
        if (body_last) begin
          state_nxt  = S_IDLE;
          cursor_nxt = FIRST_CELL;
        end
      end
      default: begin
        state_nxt = S_CLEAR;
      end
    endcase
  end

  // Control registers; reset drops any latched code and restarts the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_CLEAR;
      idx    <= 4'd0;
      cursor <= FIRST_CELL;
      cmd    <= 8'h00;
    end else begin
      state  <= state_nxt;
      cursor <= cursor_nxt;
      if (read) begin
        cmd <= char_in;
      end
      // idx wraps 15->0 at the end of a body and rests at 0 elsewhere.
      if (in_body) begin
        idx <= idx + 4'd1;
      end else begin
        idx <= 4'd0;
      end
    end
  end

  // Text store; contents are undefined until the reset clear completes.
  always_ff @(posedge clk) begin
    if (!rst && we_a) begin
      mem[addr_a] <= data_a;
    end
    if (!rst && we_b) begin
      mem[addr_b] <= BLANK;
    end
  end

  // LCD read port: registered, never stalled, reads the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_char <= BLANK;
    end else begin
      lcd_char <= mem[lcd_addr];
    end
  end

endmodule

// File: tb/tb_text_ctrl.sv
// Directed bench for text_ctrl: a behavioural model of the text store
// predicts cells, cursor and body lengths; predictions are queued when a
// character is sent and popped when the DUT result is observed.

module tb_text_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_in;
  logic       read_ready;
  logic       read;
  logic [4:0] lcd_addr;
  logic [7:0] lcd_char;
  logic [4:0] cursor;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q [$];
  logic [7:0] ref_mem [32];
  logic [4:0] ref_cur;

  always #5 clk = ~clk;

  text_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .read_ready (read_ready),
    .read       (read),
    .lcd_addr   (lcd_addr),
    .lcd_char   (lcd_char),
    .cursor     (cursor),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h20;
    ref_cur = 5'd0;
  endfunction

  function automatic void model_scroll();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]      = ref_mem[i + 16];
      ref_mem[i + 16] = 8'h20;
    end
    ref_cur = 5'd16;
  endfunction

  // Applies one code to the model; returns the expected busy length.
  function automatic int model_apply(input logic [7:0] c);
    int nb = 0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      ref_mem[ref_cur] = c;
      if (ref_cur == 5'd31) begin
        model_scroll();
        nb = 16;
      end else begin
        ref_cur = ref_cur + 5'd1;
      end
    end else if (c == 8'h08) begin
      if (ref_cur != 5'd0) begin
        ref_cur = ref_cur - 5'd1;
        ref_mem[ref_cur] = 8'h20;
      end
    end else if (c == 8'h0D) begin
      if (ref_cur < 5'd16) ref_cur = 5'd16;
      else begin
        model_scroll();
        nb = 16;
      end
    end else if (c == 8'h1B) begin
      model_clear();
      nb = 16;
    end
    return nb;
  endfunction

  task automatic sweep(input string tag);
    for (int a = 0; a < 32; a++) exp_q.push_back(ref_mem[a]);
    for (int a = 0; a < 32; a++) begin
      lcd_addr = a[4:0];
      tick();
      check($sformatf("%s[%0d]", tag, a), lcd_char, exp_q.pop_front());
    end
  endtask

  task automatic wait_busy_done(output int nb);
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      tick();
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    int nb;
    char_in    = c;
    read_ready = 1'b1;
    #1;
    n = 0;
    while (read !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check($sformatf("pop_%h", c), 8'(read), 8'h01);
    exp_q.push_back(8'(model_apply(c)));
    exp_q.push_back({3'b000, ref_cur});
    tick();
    check($sformatf("read_in_decode_%h", c), 8'(read), 8'h00);
    read_ready = 1'b0;
    tick();
    wait_busy_done(nb);
    check($sformatf("busy_len_%h", c), 8'(nb), exp_q.pop_front());
    check($sformatf("cursor_after_%h", c), {3'b000, cursor}, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst        = 1'b1;
    read_ready = 1'b0;
    char_in    = 8'h00;
    lcd_addr   = 5'd0;

    // Reset and power-on clear
    tick();
    check("rst_read", 8'(read), 8'h00);
    check("rst_cursor", {3'b000, cursor}, 8'h00);
    check("rst_lcd_char", lcd_char, 8'h20);
    check("rst_busy", 8'(busy), 8'h01);
    rst = 1'b0;
    model_clear();
    wait_busy_done(n);
    check("rst_busy_len", 8'(n), 8'd16);
    check("rst_cursor_done", {3'b000, cursor}, 8'h00);
    sweep("rst_cell");

    // Backspace at cursor 0 is a no-op
    send(8'h08);

    // Type "AB" with the buffer continuously ready
    char_in    = 8'h41;
    read_ready = 1'b1;
    #1;
    check("ab_pop1", 8'(read), 8'h01);
    void'(model_apply(8'h41));
    exp_q.push_back({3'b000, ref_cur});
    tick();
    char_in = 8'h42;
    check("ab_decode1", 8'(read), 8'h00);
    tick();
    check("ab_pop2", 8'(read), 8'h01);
    check("ab_cursor1", {3'b000, cursor}, exp_q.pop_front());
    void'(model_apply(8'h42));
    exp_q.push_back({3'b000, ref_cur});
    tick();
    read_ready = 1'b0;
    #1;
    check("ab_decode2", 8'(read), 8'h00);
    tick();
    check("ab_cursor2", {3'b000, cursor}, exp_q.pop_front());
    sweep("ab_cell");

    // Escape with text present
    send(8'h1B);
    sweep("esc_cell");

    // Fill both lines; the 32nd character triggers a scroll
    for (int i = 0; i < 32; i++) send(8'h41 + 8'(i % 26));
    sweep("scroll_cell");

    // Control codes starting at cursor 3
    send(8'h1B);
    send(8'h78);
    send(8'h79);
    send(8'h7A);
    send(8'h08);
    send(8'h0D);
    send(8'h07);
    send(8'h08);
    sweep("ctl_cell");

    // Reset in the middle of a scroll with the buffer ready
    send(8'h0D);
    char_in    = 8'h0D;
    read_ready = 1'b1;
    #1;
    n = 0;
    while (read !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("ms_pop", 8'(read), 8'h01);
    tick();
    char_in = 8'h58;
    repeat (6) tick();
    check("ms_busy", 8'(busy), 8'h01);
    check("ms_read_scroll", 8'(read), 8'h00);
    rst = 1'b1;
    #1;
    check("ms_read_rst", 8'(read), 8'h00);
    tick();
    check("ms_cursor", {3'b000, cursor}, 8'h00);
    check("ms_lcd_char", lcd_char, 8'h20);
    check("ms_busy_clear", 8'(busy), 8'h01);
    rst = 1'b0;
    #1;
    model_clear();
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      check("ms_read_clear", 8'(read), 8'h00);
      n++;
      tick();
    end
    check("ms_clear_len", 8'(n), 8'd16);
    check("ms_first_idle_pop", 8'(read), 8'h01);
    void'(model_apply(8'h58));
    exp_q.push_back({3'b000, ref_cur});
    tick();
    read_ready = 1'b0;
    tick();
    check("ms_cursor_after", {3'b000, cursor}, exp_q.pop_front());
    sweep("ms_cell");

    // Reset while idle with a ready buffer must block the pop
    char_in    = 8'h07;
    read_ready = 1'b1;
    rst        = 1'b1;
    #1;
    check("idle_rst_read", 8'(read), 8'h00);
    tick();
    rst        = 1'b0;
    read_ready = 1'b0;
    #1;
    model_clear();
    wait_busy_done(n);
    check("idle_rst_busy_len", 8'(n), 8'd16);
    check("idle_rst_cursor", {3'b000, cursor}, 8'h00);
    sweep("final_cell");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
